// File: rtl/change_dispenser_pkg.sv
// vend_pkg: shared types and constants for the change dispenser
package vend_pkg;
    localparam int MONEY_W = 5;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] D1 = 1;
    localparam logic [CNT_W-1:0] D5 = 5;
    localparam logic [CNT_W-1:0] D10 = 10;
    typedef enum logic [2:0] {IDLE, CALC, DISP10, DISP5, DISP1, GAP, DONE} state_t;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, verdict and coin-eject signals of the change dispenser
interface change_dispenser_if;
    import vend_pkg::*;
    logic i_start;
    logic [MONEY_W-1:0] i_payment;
    logic [MONEY_W-1:0] i_price;
    logic [CNT_W-1:0] i_am_1;
    logic [CNT_W-1:0] i_am_5;
    logic [CNT_W-1:0] i_am_10;
    logic o_busy;
    logic o_ch_valid;
    logic o_enough_ch;
    logic o_underpay;
    logic o_out_1;
    logic o_out_5;
    logic o_out_10;
    logic [CNT_W-1:0] o_used_1;
    logic [CNT_W-1:0] o_used_5;
    logic [CNT_W-1:0] o_used_10;
    logic o_done;
    modport master (
        output i_start, i_payment, i_price, i_am_1, i_am_5, i_am_10,
        input o_busy, o_ch_valid, o_enough_ch, o_underpay, o_out_1, o_out_5, o_out_10,
        input o_used_1, o_used_5, o_used_10, o_done
    );
    modport slave (
        input i_start, i_payment, i_price, i_am_1, i_am_5, i_am_10,
        output o_busy, o_ch_valid, o_enough_ch, o_underpay, o_out_1, o_out_5, o_out_10,
        output o_used_1, o_used_5, o_used_10, o_done
    );
endinterface

// File: rtl/change_dispenser_calc.sv
// change_calc: combinational greedy 10/5/1 change solver limited by inventory
module change_calc
    import vend_pkg::*;
(
    input  logic [CNT_W-1:0] ch,
    input  logic [CNT_W-1:0] am_1,
    input  logic [CNT_W-1:0] am_5,
    input  logic [CNT_W-1:0] am_10,
    output logic [CNT_W-1:0] n_10,
    output logic [CNT_W-1:0] n_5,
    output logic [CNT_W-1:0] n_1,
    output logic ok
);
    logic [CNT_W-1:0] q_10, q_5, r_1, r_2;
    // take the largest coins first; any remainder left after the 1s means no solution exists
    always_comb begin
        q_10 = ch / D10;
        n_10 = q_10 < am_10 ? q_10 : am_10;
        r_1 = ch - D10 * n_10;
        q_5 = r_1 / D5;
        n_5 = q_5 < am_5 ? q_5 : am_5;
        r_2 = r_1 - D5 * n_5;
        n_1 = r_2 < am_1 ? r_2 : am_1;
        ok = r_2 == n_1;
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: computes change, reports feasibility and ejects coins one pulse at a time
module change_dispenser
    import vend_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input logic clk,
    input logic i_rst_n,
    change_dispenser_if.slave bus
);
    state_t state, state_nx, ret, ret_nx;
    logic [MONEY_W-1:0] pay, price;
    logic [CNT_W-1:0] am_1, am_5, am_10, ch, n_1, n_5, n_10;
    logic [CNT_W-1:0] c_1, c_5, c_10, c_1_nx, c_5_nx, c_10_nx;
    logic [CNT_W-1:0] used_1_nx, used_5_nx, used_10_nx;
    logic [2:0] gap, gap_nx;
    logic ok, neg, cap, d_1, d_5, d_10;
    logic ch_valid_nx, enough_nx, under_nx, out_1_nx, out_5_nx, out_10_nx;

    assign ch = {1'b0, pay} - {1'b0, price};
    assign neg = ch[CNT_W-1];
    assign d_10 = c_10 != '0;
    assign d_5 = !d_10 && c_5 != '0;
    assign d_1 = !d_10 && !d_5 && c_1 != '0;
    assign bus.o_busy = state != IDLE;
    assign bus.o_done = state == DONE;

    change_calc u_calc (
        .ch(ch), .am_1(am_1), .am_5(am_5), .am_10(am_10),
        .n_10(n_10), .n_5(n_5), .n_1(n_1), .ok(ok)
    );

    // state, counters, captured request and registered outputs
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ret <= IDLE;
            gap <= '0;
            {pay, price, am_1, am_5, am_10} <= '0;
            {c_1, c_5, c_10} <= '0;
            {bus.o_used_1, bus.o_used_5, bus.o_used_10} <= '0;
            {bus.o_ch_valid, bus.o_enough_ch, bus.o_underpay} <= '0;
            {bus.o_out_1, bus.o_out_5, bus.o_out_10} <= '0;
        end else begin
            state <= state_nx;
            ret <= ret_nx;
            gap <= gap_nx;
            {c_1, c_5, c_10} <= {c_1_nx, c_5_nx, c_10_nx};
            {bus.o_used_1, bus.o_used_5, bus.o_used_10} <= {used_1_nx, used_5_nx, used_10_nx};
            {bus.o_ch_valid, bus.o_enough_ch, bus.o_underpay} <= {ch_valid_nx, enough_nx, under_nx};
            {bus.o_out_1, bus.o_out_5, bus.o_out_10} <= {out_1_nx, out_5_nx, out_10_nx};
            if (cap) begin
                pay <= bus.i_payment;
                price <= bus.i_price;
                {am_1, am_5, am_10} <= {bus.i_am_1, bus.i_am_5, bus.i_am_10};
            end
        end
    end

    // next state; every verdict enters DISP10 so failed and zero-change requests finish with the same latency
    always_comb begin
        state_nx = state;
        ret_nx = ret;
        gap_nx = gap;
        {c_1_nx, c_5_nx, c_10_nx} = {c_1, c_5, c_10};
        {used_1_nx, used_5_nx, used_10_nx} = {bus.o_used_1, bus.o_used_5, bus.o_used_10};
        ch_valid_nx = 1'b0;
        enough_nx = bus.o_enough_ch;
        under_nx = bus.o_underpay;
        {out_1_nx, out_5_nx, out_10_nx} = '0;
        cap = 1'b0;
        case (state)
            IDLE: if (bus.i_start) begin
                cap = 1'b1;
                {used_1_nx, used_5_nx, used_10_nx} = '0;
                state_nx = CALC;
            end
            CALC: begin
                ch_valid_nx = 1'b1;
                under_nx = neg;
                enough_nx = !neg && ok;
                c_10_nx = enough_nx ? n_10 : '0;
                c_5_nx = enough_nx ? n_5 : '0;
                c_1_nx = enough_nx ? n_1 : '0;
                state_nx = DISP10;
            end
            DISP10, DISP5, DISP1: begin
                {out_1_nx, out_5_nx, out_10_nx} = {d_1, d_5, d_10};
                c_10_nx = c_10 - CNT_W'(d_10);
                c_5_nx = c_5 - CNT_W'(d_5);
                c_1_nx = c_1 - CNT_W'(d_1);
                used_10_nx = bus.o_used_10 + CNT_W'(d_10);
                used_5_nx = bus.o_used_5 + CNT_W'(d_5);
                used_1_nx = bus.o_used_1 + CNT_W'(d_1);
                ret_nx = d_10 ? DISP10 : d_5 ? DISP5 : DISP1;
                gap_nx = 3'(GAP_CYCLES - 1);
                state_nx = !(d_10 || d_5 || d_1) ? DONE : GAP_CYCLES == 0 ? ret_nx : GAP;
            end
            GAP: begin
                gap_nx = gap - 3'd1;
                state_nx = gap == '0 ? ret : GAP;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed transactions checked every cycle against a brute-force change model
module tb_change_dispenser;
    import vend_pkg::*;
    localparam int G = 1;
    localparam int P = 1 + G;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    change_dispenser_if bus();
    change_dispenser #(.GAP_CYCLES(G)) dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));

    int tests = 0, errors = 0, cyc = 0;
    int t0, k, j, npulse, done_k;
    bit active = 1'b0;
    int exp_n, exp_d, exp_u1, exp_u5, exp_u10;
    bit exp_under, exp_enough;
    int coins[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // search every coin mix, preferring most 10s then most 5s
    task automatic model(input int pay, input int price, input int a1, input int a5, input int a10);
        int ch, c;
        bit found;
        found = 1'b0;
        exp_u1 = 0;
        exp_u5 = 0;
        exp_u10 = 0;
        coins.delete();
        exp_under = price > pay;
        ch = pay - price;
        if (!exp_under)
            for (int a = a10; a >= 0 && !found; a--)
                for (int b = a5; b >= 0 && !found; b--) begin
                    c = ch - 10 * a - 5 * b;
                    if (c >= 0 && c <= a1) begin
                        found = 1'b1;
                        exp_u10 = a;
                        exp_u5 = b;
                        exp_u1 = c;
                    end
                end
        exp_enough = found;
        repeat (exp_u10) coins.push_back(10);
        repeat (exp_u5) coins.push_back(5);
        repeat (exp_u1) coins.push_back(1);
        exp_n = coins.size();
        exp_d = 3 + exp_n * P;
    endtask

    task automatic run_txn(input int pay, input int price, input int a1, input int a5, input int a10);
        @(negedge clk);
        bus.i_payment = 5'(pay);
        bus.i_price = 5'(price);
        bus.i_am_1 = 6'(a1);
        bus.i_am_5 = 6'(a5);
        bus.i_am_10 = 6'(a10);
        model(pay, price, a1, a5, a10);
        t0 = cyc;
        npulse = 0;
        done_k = -1;
        active = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && active; i++) @(negedge clk);
        chk({name, "_timeout"}, int'(active), 0);
        active = 1'b0;
    endtask

    // per-cycle comparison against the model timeline
    always @(posedge clk) begin
        #1;
        if (rst_n && active) begin
            k = cyc - t0;
            j = (k >= 3 && (k - 3) % P == 0 && (k - 3) / P < exp_n) ? (k - 3) / P : -1;
            chk("busy", int'(bus.o_busy), int'(k <= exp_d));
            chk("ch_valid", int'(bus.o_ch_valid), int'(k == 2));
            if (k >= 2) begin
                chk("enough_ch", int'(bus.o_enough_ch), int'(exp_enough));
                chk("underpay", int'(bus.o_underpay), int'(exp_under));
            end
            chk("out_10", int'(bus.o_out_10), int'(j >= 0 && coins[j] == 10));
            chk("out_5", int'(bus.o_out_5), int'(j >= 0 && coins[j] == 5));
            chk("out_1", int'(bus.o_out_1), int'(j >= 0 && coins[j] == 1));
            npulse += int'(bus.o_out_1) + int'(bus.o_out_5) + int'(bus.o_out_10);
            chk("done", int'(bus.o_done), int'(k == exp_d));
            if (bus.o_done) done_k = k;
            if (k == exp_d) begin
                chk("used_10", int'(bus.o_used_10), exp_u10);
                chk("used_5", int'(bus.o_used_5), exp_u5);
                chk("used_1", int'(bus.o_used_1), exp_u1);
            end
            if (k > exp_d) active = 1'b0;
        end else if (rst_n) begin
            chk("idle_busy", int'(bus.o_busy), 0);
            chk("idle_pulses", int'({bus.o_out_1, bus.o_out_5, bus.o_out_10, bus.o_ch_valid, bus.o_done}), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_payment = '0;
        bus.i_price = '0;
        bus.i_am_1 = '0;
        bus.i_am_5 = '0;
        bus.i_am_10 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_flags", int'({bus.o_ch_valid, bus.o_enough_ch, bus.o_underpay, bus.o_done}), 0);
        chk("rst_used", int'({bus.o_used_1, bus.o_used_5, bus.o_used_10}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(17, 5, 6, 2, 1);
        wait_idle("t1");
        chk("t1_done_cycle", done_k, 9);
        chk("t1_pulses", npulse, 3);
        chk("t1_used_1", int'(bus.o_used_1), 2);
        chk("t1_used_10", int'(bus.o_used_10), 1);

        run_txn(15, 0, 3, 0, 1);
        wait_idle("t2");
        chk("t2_done_cycle", done_k, 3);
        chk("t2_enough", int'(bus.o_enough_ch), 0);
        chk("t2_pulses", npulse, 0);

        run_txn(4, 9, 10, 10, 10);
        wait_idle("t3");
        chk("t3_underpay", int'(bus.o_underpay), 1);
        chk("t3_enough", int'(bus.o_enough_ch), 0);

        run_txn(8, 8, 0, 0, 0);
        wait_idle("t4");
        chk("t4_enough", int'(bus.o_enough_ch), 1);
        chk("t4_done_cycle", done_k, 3);

        run_txn(25, 0, 0, 1, 2);
        repeat (2) @(negedge clk);
        bus.i_payment = 5'd31;
        bus.i_am_1 = 6'd63;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_idle("t5");
        chk("t5_pulses", npulse, 3);
        chk("t5_used_10", int'(bus.o_used_10), 2);
        chk("t5_used_5", int'(bus.o_used_5), 1);

        run_txn(30, 3, 5, 5, 0);
        wait_idle("t6");
        chk("t6_done_cycle", done_k, 17);

        run_txn(31, 0, 1, 0, 3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_pulses", npulse, 2);
        active = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(bus.o_busy), 0);
        chk("rst_mid_out", int'({bus.o_out_1, bus.o_out_5, bus.o_out_10}), 0);
        chk("rst_mid_used", int'({bus.o_used_1, bus.o_used_5, bus.o_used_10}), 0);
        chk("rst_mid_flags", int'({bus.o_ch_valid, bus.o_enough_ch, bus.o_underpay, bus.o_done}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        run_txn(31, 0, 63, 63, 63);
        wait_idle("t8");
        chk("t8_pulses", npulse, 4);

        run_txn(0, 0, 0, 0, 0);
        wait_idle("t9");
        chk("t9_enough", int'(bus.o_enough_ch), 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
